// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid buffer between pipeline stages with flush, stall, halt and bubble count
module pipe_stage_buf #(
    parameter int               WIDTH    = 32,
    parameter int               HALT_BIT = 0,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic             halted,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] h_data, h_data_n;
    logic [WIDTH-1:0] s_data, s_data_n;
    logic             halted_n;
    logic             in_ready_reg, in_ready_n;
    logic [CNT_W-1:0] bubble_n;
    logic             h_valid, acc, emt, bubble_inc;

    assign h_valid    = (state != EMPTY);
    assign in_ready   = in_ready_reg && !RST;
    assign acc        = in_valid && in_ready && !stall && !flush;
    assign emt        = h_valid && out_ready && !stall && !flush;
    assign out_valid  = h_valid && !stall;
    assign out_data   = h_data;
    assign occupancy  = state;
    assign bubble_inc = out_ready && !out_valid && !stall && !flush;

    always_comb begin
        state_n  = state;
        h_data_n = h_data;
        s_data_n = s_data;
        if (flush) begin
            state_n  = EMPTY;
            h_data_n = RST_VAL;
            s_data_n = RST_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_n  = ONE;
                        h_data_n = in_data;
                    end
                end
                ONE: begin
                    if (acc && emt) begin
                        h_data_n = in_data;
                    end else if (acc) begin
                        state_n  = FULL;
                        s_data_n = in_data;
                    end else if (emt) begin
                        state_n  = EMPTY;
                        h_data_n = RST_VAL;
                    end
                end
                FULL: begin
                    if (emt) begin
                        state_n  = ONE;
                        h_data_n = s_data;
                        s_data_n = RST_VAL;
                    end
                end
                default: begin
                    state_n  = EMPTY;
                    h_data_n = RST_VAL;
                    s_data_n = RST_VAL;
                end
            endcase
        end

        // Only a payload that actually leaves the buffer can raise halt
        halted_n   = halted || (emt && h_data[HALT_BIT]);
        in_ready_n = (state_n != FULL) && !halted_n;

        bubble_n = bubble_cnt;
        if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_n = bubble_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= EMPTY;
            h_data       <= RST_VAL;
            s_data       <= RST_VAL;
            halted       <= 1'b0;
            in_ready_reg <= 1'b1;
            bubble_cnt   <= '0;
        end else begin
            state        <= state_n;
            h_data       <= h_data_n;
            s_data       <= s_data_n;
            halted       <= halted_n;
            in_ready_reg <= in_ready_n;
            bubble_cnt   <= bubble_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf
module tb_pipe_stage_buf;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid, out_ready, stall, flush;
    logic [7:0] in_data;

    logic       rdy0, vld0, hlt0;
    logic [7:0] dat0;
    logic [1:0] occ0, bub0;
    logic       rdy1, vld1, hlt1;
    logic [7:0] dat1;
    logic [1:0] occ1, bub1;

    logic       sel;
    logic       m_ready, m_valid, m_halted;
    logic [7:0] m_data;
    logic [1:0] m_occ, m_bub;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    // Halt on bit 0 for most scenarios; the streaming run uses bit 7 so odd payloads flow
    pipe_stage_buf #(.WIDTH(8), .HALT_BIT(0), .CNT_W(2), .RST_VAL(8'h00)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .stall(stall), .flush(flush),
        .halted(hlt0), .occupancy(occ0), .bubble_cnt(bub0)
    );

    pipe_stage_buf #(.WIDTH(8), .HALT_BIT(7), .CNT_W(2), .RST_VAL(8'h00)) dut_s (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .stall(stall), .flush(flush),
        .halted(hlt1), .occupancy(occ1), .bubble_cnt(bub1)
    );

    assign m_ready  = sel ? rdy1 : rdy0;
    assign m_valid  = sel ? vld1 : vld0;
    assign m_data   = sel ? dat1 : dat0;
    assign m_halted = sel ? hlt1 : hlt0;
    assign m_occ    = sel ? occ1 : occ0;
    assign m_bub    = sel ? bub1 : bub0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        RST = 1'b0;
        settle();
    endtask

    // Monitor: a transfer completes at the next edge whenever out_valid && out_ready && !flush
    always @(negedge CLK) begin
        if (!RST && m_valid && out_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_emit: got 0x%0h expected none", m_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL emit_data: got 0x%0h expected 0x%0h", m_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b1;
        RST = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        step();
        chk("rst_in_ready", m_ready, 0);
        chk("rst_occ", m_occ, 0);
        chk("rst_out_valid", m_valid, 0);
        chk("rst_out_data", m_data, 8'h00);
        RST = 1'b0;
        settle();
        chk("post_rst_in_ready", m_ready, 1);

        // Streaming through the bit-7 halt instance
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
            step();
            chk("stream_occ", m_occ, 1);
            chk("stream_in_ready", m_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_occ", m_occ, 0);

        sel = 1'b0;
        do_reset();

        // Backpressure
        in_valid = 1'b1; in_data = 8'hA0; exp_q.push_back(8'hA0);
        step();
        chk("bp_occ1", m_occ, 1);
        in_data = 8'hA1; exp_q.push_back(8'hA1);
        step();
        chk("bp_occ2", m_occ, 2);
        chk("bp_in_ready_full", m_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_occ_after_emit", m_occ, 1);
        chk("bp_in_ready_back", m_ready, 1);
        step();
        chk("bp_occ_drained", m_occ, 0);
        chk("bp_halt_a1", m_halted, 1);
        do_reset();

        // Flush of a full buffer with a same-cycle input
        in_valid = 1'b1; in_data = 8'hB0;
        step();
        in_data = 8'hB1;
        step();
        chk("fl_full", m_occ, 2);
        flush = 1'b1; in_data = 8'hB2;
        step();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("fl_occ", m_occ, 0);
        chk("fl_out_valid", m_valid, 0);
        chk("fl_out_data", m_data, 8'h00);
        chk("fl_halted", m_halted, 0);
        out_ready = 1'b1;
        step();
        chk("fl_bubble", m_bub, 1);
        out_ready = 1'b0;

        // Stall holding one entry
        in_valid = 1'b1; in_data = 8'hC0; exp_q.push_back(8'hC0);
        step();
        chk("st_occ", m_occ, 1);
        stall = 1'b1; out_ready = 1'b1; in_data = 8'hC2;
        settle();
        chk("st_out_valid", m_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_occ", m_occ, 1);
            chk("st_bubble", m_bub, 1);
        end
        stall = 1'b0; in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("st_released_occ", m_occ, 0);
        chk("st_bubble_after", m_bub, 1);
        do_reset();

        // Halt payload removed by flush does not halt
        in_valid = 1'b1; in_data = 8'h01;
        step();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        chk("fh_halted", m_halted, 0);
        chk("fh_occ", m_occ, 0);
        step();
        chk("fh_halted_later", m_halted, 0);
        do_reset();

        // Halt: 0x01 sets halted, buffered 0x04 still drains, 0x08 is refused
        in_valid = 1'b1; in_data = 8'h01; exp_q.push_back(8'h01);
        step();
        in_data = 8'h04; exp_q.push_back(8'h04);
        step();
        in_data = 8'h08; out_ready = 1'b1;
        step();
        chk("h_halted", m_halted, 1);
        chk("h_in_ready", m_ready, 0);
        chk("h_occ", m_occ, 1);
        step();
        out_ready = 1'b0;
        chk("h_drained", m_occ, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("h_no_accept", m_occ, 0);
        end
        in_valid = 1'b0;

        // Bubble saturation, then reset clears everything
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bub_cnt", m_bub, (i < 3) ? (i + 1) : 3);
        end
        RST = 1'b1;
        step();
        chk("rst2_bubble", m_bub, 0);
        chk("rst2_halted", m_halted, 0);
        chk("rst2_occ", m_occ, 0);
        chk("rst2_in_ready", m_ready, 0);
        RST = 1'b0; out_ready = 1'b0;
        settle();
        chk("rst2_in_ready_after", m_ready, 1);
        step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage latches (if/id, id/ex, ex/mem, mem/wb).
- Carries one opaque WIDTH-bit payload between pipeline stages over a valid/ready handshake.
- Two-entry skid buffer, so in_ready is registered and never depends combinationally on out_ready.
- Adds flush, stall (hold), sticky halt detection and a saturating bubble counter.
- Instantiated between every pipeline stage in place of the per-stage hand-written registers.

Parameters:
- WIDTH, 32: payload width in bits; must be >= 1.
- HALT_BIT, 0: index of the payload bit that marks a halt instruction; range 0..WIDTH-1.
- CNT_W, 16: bubble counter width.
- RST_VAL, 0: payload value loaded into both entries on reset and flush.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  buffer accepts this cycle (registered).
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry is valid and not stalled.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  head payload.
- stall  in  1  hold: no accept, no emit.
- flush  in  1  discard all contents.
- halted  out  1  sticky; a halt payload has left the buffer.
- occupancy  out  2  number of valid entries, 0..2.
- bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0, saturating.

Behaviour:
- Reset: RST=1 at a rising edge clears both entries (valid=0, data=RST_VAL), halted, occupancy and bubble_cnt to 0. in_ready=0 while RST=1 and 1 in the first cycle after.
- Storage: head entry H (drives out_data) and skid entry S. in_ready_reg = !S.valid && !halted && !RST, registered.
- Accept: acc = in_valid && in_ready && !stall && !flush.
- Emit: emt = H.valid && out_ready && !stall && !flush.
- out_valid = H.valid && !stall. out_data = H.data, always driven (RST_VAL when empty).
- State is encoded by occupancy: EMPTY(0), ONE(1), FULL(2). Transitions:
  - EMPTY: acc -> ONE; data goes to H. Zero bubble: out_valid is seen the cycle after acceptance.
  - ONE: acc and emt -> ONE; H takes in_data. acc only -> FULL; S takes in_data. emt only -> EMPTY.
  - FULL: in_ready=0. emt -> ONE; H takes S.data and S is cleared. No emt -> hold.
- Ordering is strict FIFO. S is never valid while H is empty.
- Flush: highest priority after RST. Next cycle H and S are invalid with data RST_VAL and occupancy=0. Any same-cycle input is dropped. Flush does not clear halted or bubble_cnt.
- Stall: freezes all entries. in_ready is masked to 0 combinationally in the accept term. out_valid is forced to 0. bubble_cnt does not count while stalled. Flush overrides stall.
- Halt:
  - When emt occurs with H.data[HALT_BIT]=1, halted is set at the next edge and stays set until RST.
  - Once halted=1, in_ready=0 permanently and no further accepts occur.
  - Entries already buffered may still drain.
  - A halt payload removed by flush does not set halted.
- bubble_cnt increments by 1 when out_ready && !out_valid && !stall && !flush. It saturates at 2^CNT_W-1.
- Simultaneous accept and emit at occupancy 1 is legal and keeps throughput at 1 per cycle.
- Reset asserted mid-transfer: RST wins over acc, emt and flush. No payload survives.
- X on in_data is ignored when in_valid=0.

Test Plan:
- Streaming: in_data 0x10,0x11,0x12,0x13 with in_valid=1 and out_ready=1 -> out_data emits 0x10..0x13 on consecutive cycles, starting 1 cycle after first accept; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0, push 0xA0 then 0xA1 -> occupancy=2 and in_ready=0 next cycle. Then out_ready=1 -> emits 0xA0 then 0xA1, and in_ready returns to 1 after the first emit.
- Flush: with FULL (0xB0, 0xB1), assert flush alongside in_valid carrying 0xB2 -> next cycle occupancy=0, out_valid=0, out_data=RST_VAL; 0xB2 never emitted.
- Stall: ONE holding 0xC0, stall=1 for 3 cycles with out_ready=1 -> out_valid=0, no accepts, bubble_cnt unchanged. Release -> 0xC0 emitted.
- Halt (HALT_BIT=0): push 0x01 then 0x04 -> 0x01 emitted, halted=1 next cycle; 0x04 already buffered still drains; subsequent in_valid with 0x08 is never accepted. A flushed 0x01 leaves halted=0.
- Bubbles and reset (CNT_W=2): hold out_ready=1 with buffer empty for 5 cycles -> bubble_cnt=3 (saturated). Assert RST -> bubble_cnt=0, halted=0, occupancy=0.
